// File: rtl/systolic_os_sequencer.sv
`default_nettype none
// ============================================================================
// systolic_os_sequencer
// Feeds an NxN output-stationary systolic array (mode=1) with paired
// A-column / B-row vectors, then flushes the skew and drains the result
// rows into a result stream. Zero vectors are used for stalls and clearing.
// Revision: 1.0
// ============================================================================
module systolic_os_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int SUM_WIDTH      = 16,
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int KW             = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [KW-1:0]                         k_len_i,
  output logic                                  busy_o,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  a_vec_i,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  b_vec_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  arr_a_o,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0]  arr_b_o,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]   arr_sum_o,
  output logic                                  arr_mode_o,
  output logic                                  arr_state_o,
  output logic                                  arr_enable_o,
  input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]   arr_sum_out_i,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]   res_vec_o,
  output logic [$clog2(SYSTOLIC_WIDTH)-1:0]     res_row_o,
  output logic                                  res_valid_o,
  output logic                                  done_o
);

  localparam int N   = SYSTOLIC_WIDTH;
  localparam int RW  = $clog2(N);
  // One shared counter: must reach k_len (FEED) and 2N-2 (FLUSH).
  localparam int CW  = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
  localparam int VW  = N * DATA_WIDTH;
  localparam int SVW = N * SUM_WIDTH;

  localparam logic [CW-1:0] CLEAR_LAST = CW'(N);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);
  localparam logic [RW-1:0] TOP_ROW    = RW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic [KW-1:0]     k_len_q, k_len_d;
  logic [VW-1:0]     arr_a_q, arr_a_d;
  logic [VW-1:0]     arr_b_q, arr_b_d;
  logic              arr_state_q, arr_state_d;
  logic              arr_enable_q, arr_enable_d;
  logic              in_ready_q, in_ready_d;
  logic [SVW-1:0]    res_vec_q, res_vec_d;
  logic [RW-1:0]     res_row_q, res_row_d;
  logic              res_valid_q, res_valid_d;
  logic              done_q, done_d;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_len_d     = k_len_q;
    arr_a_d     = '0;
    arr_b_d     = '0;
    res_vec_d   = res_vec_q;
    res_row_d   = res_row_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == CLEAR_LAST) begin
          cnt_d   = '0;
          state_d = (k_len_q == '0) ? FLUSH : FEED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FEED: begin
        // No handshake leaves the zero defaults in place: a harmless bubble.
        if (in_valid_i && in_ready_q) begin
          arr_a_d = a_vec_i;
          arr_b_d = b_vec_i;
          if (cnt_inc == CW'(k_len_q)) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DRAIN: begin
        // Bottom row comes out first; each shift exposes the next row up.
        res_vec_d   = arr_sum_out_i;
        res_row_d   = TOP_ROW - cnt_q[RW-1:0];
        res_valid_d = 1'b1;
        done_d      = (cnt_q == DRAIN_LAST);
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Array controls are registered so they line up with the state they describe.
    arr_state_d  = (state_d == FEED) || (state_d == FLUSH);
    arr_enable_d = (state_d != IDLE);
    in_ready_d   = (state_d == FEED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_len_q      <= '0;
      arr_a_q      <= '0;
      arr_b_q      <= '0;
      arr_state_q  <= 1'b0;
      arr_enable_q <= 1'b0;
      in_ready_q   <= 1'b0;
      res_vec_q    <= '0;
      res_row_q    <= '0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_len_q      <= k_len_d;
      arr_a_q      <= arr_a_d;
      arr_b_q      <= arr_b_d;
      arr_state_q  <= arr_state_d;
      arr_enable_q <= arr_enable_d;
      in_ready_q   <= in_ready_d;
      res_vec_q    <= res_vec_d;
      res_row_q    <= res_row_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign in_ready_o   = in_ready_q;
  assign arr_a_o      = arr_a_q;
  assign arr_b_o      = arr_b_q;
  assign arr_sum_o    = '0;
  assign arr_mode_o   = 1'b1;
  assign arr_state_o  = arr_state_q;
  assign arr_enable_o = arr_enable_q;
  assign res_vec_o    = res_vec_q;
  assign res_row_o    = res_row_q;
  assign res_valid_o  = res_valid_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_os_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_systolic_os_sequencer
// Directed bench: a behavioural output-stationary array answers the
// sequencer, and result rows are compared with hand-computed matrices.
// Revision: 1.0
// ============================================================================
module tb_systolic_os_sequencer;

  localparam int DW = 16;
  localparam int SW = 16;
  localparam int N  = 4;
  localparam int KW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [KW-1:0]     k_len_i = '0;
  logic              busy_o;
  logic [N*DW-1:0]   a_vec_i = '0;
  logic [N*DW-1:0]   b_vec_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [N*DW-1:0]   arr_a_o, arr_b_o;
  logic [N*SW-1:0]   arr_sum_o;
  logic              arr_mode_o, arr_state_o, arr_enable_o;
  logic [N*SW-1:0]   arr_sum_out_i;
  logic [N*SW-1:0]   res_vec_o;
  logic [1:0]        res_row_o;
  logic              res_valid_o, done_o;

  always #5 clk = ~clk;

  systolic_os_sequencer #(
    .DATA_WIDTH(DW), .SUM_WIDTH(SW), .SYSTOLIC_WIDTH(N), .KW(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .a_vec_i(a_vec_i), .b_vec_i(b_vec_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .arr_a_o(arr_a_o), .arr_b_o(arr_b_o), .arr_sum_o(arr_sum_o),
    .arr_mode_o(arr_mode_o), .arr_state_o(arr_state_o),
    .arr_enable_o(arr_enable_o), .arr_sum_out_i(arr_sum_out_i),
    .res_vec_o(res_vec_o), .res_row_o(res_row_o),
    .res_valid_o(res_valid_o), .done_o(done_o)
  );

  // Idealised array: accumulate outer products in compute, shift rows down in clear/drain.
  logic [SW-1:0] acc [N][N];
  logic          poison = 1'b0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (poison) acc[i][j] <= 16'hBEEF;
        else if (arr_enable_o) begin
          if (arr_state_o)
            acc[i][j] <= acc[i][j] + SW'(arr_a_o[i*DW +: DW] * arr_b_o[j*DW +: DW]);
          else if (i == 0)
            acc[i][j] <= '0;
          else
            acc[i][j] <= acc[i-1][j];
        end
      end
    end
  end

  // Bottom row of the array model is what the sequencer drains.
  always_comb begin
    arr_sum_out_i = '0;
    for (int j = 0; j < N; j++) arr_sum_out_i[j*SW +: SW] = acc[N-1][j];
  end

  // Handshake counter used to pick the next operand pair.
  int hs_total;
  always @(posedge clk) if (in_valid_i && in_ready_o) hs_total <= hs_total + 1;

  logic [DW-1:0] A  [N][N];
  logic [DW-1:0] B  [N][N];
  logic [SW-1:0] CE [N][N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*SW-1:0] pack_row(input int r);
    logic [N*SW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*SW +: SW] = CE[r][j];
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ctl"},  64'({busy_o, in_ready_o, arr_state_o, arr_enable_o, res_valid_o, done_o}), 64'd0);
    check({tag, "_arra"}, arr_a_o, 64'd0);
    check({tag, "_arrb"}, arr_b_o, 64'd0);
    check({tag, "_sum"},  arr_sum_o, 64'd0);
    check({tag, "_res"},  res_vec_o, 64'd0);
    check({tag, "_row"},  64'(res_row_o), 64'd0);
    check({tag, "_mode"}, 64'(arr_mode_o), 64'd1);
  endtask

  task automatic set_mats(input int kind);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0: begin  // identity x [[1..4],[5..8],[9..12],[13..16]]
            A[i][j]  = (i == j) ? 16'd1 : 16'd0;
            B[i][j]  = 16'(4 * i + j + 1);
            CE[i][j] = 16'(4 * i + j + 1);
          end
          1: begin A[i][j] = 16'd3; B[i][j] = 16'd3; CE[i][j] = 16'd36; end
          2: begin A[i][j] = 16'd1; B[i][j] = 16'd1; CE[i][j] = 16'd2;  end
          3: begin A[i][j] = 16'd7; B[i][j] = 16'd9; CE[i][j] = 16'd0;  end
          default: begin A[i][j] = 16'h0100; B[i][j] = 16'h0100; CE[i][j] = 16'h0000; end
        endcase
      end
    end
  endtask

  // Runs one tile; abort_at > 0 pulls rst_n low in that cycle instead of finishing.
  task automatic run_tile(input string tag, input int k, input bit stall, input int abort_at);
    int base, c, beat, feed, busyc, kk, exp_feed, exp_done;
    bit got_done;
    exp_feed = stall ? ((k == 0) ? 0 : 2 * k - 1) : k;
    exp_done = (N + 1) + exp_feed + (2 * N - 1) + N + 1;
    @(negedge clk);
    base = hs_total;
    start_i = 1'b1;
    k_len_i = k[KW-1:0];
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    c = 1; beat = 0; feed = 0; busyc = 0; got_done = 1'b0;
    while (c < 200 && !got_done) begin
      if (in_ready_o) feed++;
      if (busy_o) busyc++;
      if (res_valid_o) begin
        check({tag, "_row"}, 64'(res_row_o), 64'(N - 1 - beat));
        check({tag, "_vec"}, res_vec_o, pack_row(N - 1 - beat));
        check({tag, "_done"}, 64'(done_o), (beat == N - 1) ? 64'd1 : 64'd0);
        if (beat == N - 1) begin
          check({tag, "_lat"}, 64'(c), 64'(exp_done));
          got_done = 1'b1;
        end
        beat++;
      end
      if (abort_at > 0 && c == abort_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle({tag, "_rst"});
        for (int w = 0; w < 3; w++) begin
          @(posedge clk);
          @(negedge clk);
          check({tag, "_rstv"}, 64'({res_valid_o, busy_o}), 64'd0);
        end
        in_valid_i = 1'b0;
        rst_n = 1'b1;
        return;
      end
      kk = hs_total - base;
      in_valid_i = stall ? (c % 2 == 0) : 1'b1;
      start_i = stall && (c == 3);  // must be ignored while busy
      a_vec_i = '0;
      b_vec_i = '0;
      if (kk < k) begin
        for (int i = 0; i < N; i++) begin
          a_vec_i[i*DW +: DW] = A[i][kk];
          b_vec_i[i*DW +: DW] = B[kk][i];
        end
      end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    in_valid_i = 1'b0;
    start_i = 1'b0;
    check({tag, "_fin"}, 64'(got_done), 64'd1);
    check({tag, "_feed"}, 64'(feed), 64'(exp_feed));
    check({tag, "_busy"}, 64'(busyc), 64'(exp_done - 1));
    check({tag, "_hs"}, 64'(hs_total - base), 64'(k));
  endtask

  initial begin
    hs_total = 0;
    poison = 1'b1;
    @(posedge clk);
    @(negedge clk);
    poison = 1'b0;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    set_mats(0); run_tile("ident", 4, 1'b0, 0);
    set_mats(0); run_tile("stall", 4, 1'b1, 0);
    set_mats(1); run_tile("all3",  4, 1'b0, 0);
    set_mats(2); run_tile("all1",  2, 1'b0, 0);
    set_mats(3); run_tile("k0",    0, 1'b0, 0);
    set_mats(4); run_tile("ovf",   1, 1'b0, 0);
    set_mats(0); run_tile("abort", 4, 1'b0, 12);
    set_mats(0); run_tile("after", 4, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
